// File: rtl/bus_mem_responder_pkg.sv
// Widths, FSM state encodings and bus defaults shared by bus_mem_responder and its RAM.
// Optional macro MEM_WAIT_EN adds the WAIT state and wait-state counter parameters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package bus_mem_responder_pkg;

   localparam int unsigned DATA_WIDTH = `DATA_WIDTH;
   localparam int unsigned ADDR_WIDTH = 2 * DATA_WIDTH;
   localparam int unsigned MEM_AW     = 8;

`ifdef MEM_WAIT_EN
   localparam int unsigned WAIT_CYCLES = 2;
   localparam int unsigned WAIT_W      = $clog2(WAIT_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRIVE = 3'd2,
      ST_WACK  = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_WACK  = 2'd3
   } state_t;
`endif

   // Upper address bits are ignored, so the array aliases modulo its depth.
   function automatic logic [MEM_AW-1:0] mem_index(input logic [ADDR_WIDTH-1:0] addr);
      return addr[MEM_AW-1:0];
   endfunction

endpackage

// File: rtl/bus_mem_responder_mem_array.sv
// Synchronous RAM with registered read data and no reset, so contents survive reset.
module bus_mem_responder_mem_array #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/bus_mem_responder.sv
// Byte-wide memory responder on the CPU address/data bus: FSM, address latch and tri-state drive.
// Optional macro MEM_WAIT_EN inserts WAIT_CYCLES wait states before READ and WRITE_ACK.
module bus_mem_responder
   import bus_mem_responder_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  CS,
   input  logic                  OE,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] address,
   inout  wire  [DATA_WIDTH-1:0] data,
   output logic                  RDY,
   output logic                  busy
);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   rd_q;
   logic                    mem_we;
   logic                    drive;

`ifdef MEM_WAIT_EN
   logic [WAIT_W-1:0]       wait_cnt;
   logic                    wait_rd;
`endif

   // Writes commit on the accepting edge; reset on that same edge suppresses them.
   assign mem_we = (state == ST_IDLE) && CS && WE && !reset;

   bus_mem_responder_mem_array #(
      .AW(MEM_AW),
      .DW(DATA_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_index(address)),
      .wdata (data),
      .raddr (mem_index(addr_q)),
      .rdata (rd_q)
   );

   // Bus released the moment CS or OE falls, even before the FSM leaves DRIVE.
   assign drive = (state == ST_DRIVE) && CS && OE;
   assign data  = drive ? rd_q : 'z;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         RDY    <= 1'b0;
         busy   <= 1'b0;
         addr_q <= '0;
`ifdef MEM_WAIT_EN
         wait_cnt <= '0;
         wait_rd  <= 1'b0;
`endif
      end else begin
         RDY  <= 1'b0;
         busy <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (CS && WE) begin
`ifdef MEM_WAIT_EN
                  state    <= ST_WAIT;
                  wait_cnt <= WAIT_W'(WAIT_CYCLES);
                  wait_rd  <= 1'b0;
`else
                  state <= ST_WACK;
                  RDY   <= 1'b1;
`endif
               end else if (CS && OE) begin
                  addr_q <= address;
`ifdef MEM_WAIT_EN
                  state    <= ST_WAIT;
                  wait_cnt <= WAIT_W'(WAIT_CYCLES);
                  wait_rd  <= 1'b1;
`else
                  state <= ST_READ;
`endif
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_READ: begin
               state <= ST_DRIVE;
               RDY   <= 1'b1;
            end
            ST_DRIVE: begin
               if (CS && OE) begin
                  if (address != addr_q) begin
                     addr_q <= address;
                     state  <= ST_READ;
                  end else begin
                     RDY <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_WACK: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
`ifdef MEM_WAIT_EN
            ST_WAIT: begin
               if (!CS) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (wait_cnt <= WAIT_W'(1)) begin
                  if (wait_rd) begin
                     state <= ST_READ;
                  end else begin
                     state <= ST_WACK;
                     RDY   <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: vector table plus hand-written corner sequences.
module tb_bus_mem_responder;
   import bus_mem_responder_pkg::*;

`ifdef MEM_WAIT_EN
   localparam int LAT = WAIT_CYCLES;
`else
   localparam int LAT = 0;
`endif

   logic                  clk;
   logic                  reset;
   logic                  CS;
   logic                  OE;
   logic                  WE;
   logic [ADDR_WIDTH-1:0] address;
   wire  [DATA_WIDTH-1:0] data;
   logic                  RDY;
   logic                  busy;

   logic                  tb_en;
   logic [DATA_WIDTH-1:0] tb_val;

   int tests = 0;
   int fails = 0;
   logic [DATA_WIDTH-1:0] sb_q[$];

   typedef struct {
      logic [ADDR_WIDTH-1:0] waddr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [ADDR_WIDTH-1:0] raddr;
      logic [DATA_WIDTH-1:0] rexp;
   } vec_t;

   vec_t vecs[6];

   assign data = tb_en ? tb_val : 'z;

   bus_mem_responder dut (
      .clk     (clk),
      .reset   (reset),
      .CS      (CS),
      .OE      (OE),
      .WE      (WE),
      .address (address),
      .data    (data),
      .RDY     (RDY),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_released(input string name);
      tests++;
      if (!($isunknown(data) || data == '0)) begin
         fails++;
         $display("FAIL %s: bus driven with 0x%0h, expected released", name, data);
      end
   endtask

   task automatic sb_pop_check(input string name);
      logic [DATA_WIDTH-1:0] e;
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: RDY with empty scoreboard, bus 0x%0h", name, data);
      end else begin
         e = sb_q.pop_front();
         check(name, 32'(data), 32'(e));
      end
   endtask

   task automatic write_op(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] v,
                           input string name);
      CS = 1'b1; WE = 1'b1; OE = 1'b0; address = a; tb_en = 1'b1; tb_val = v;
      step();
      WE = 1'b0; tb_en = 1'b0;
      #1;
      for (int k = 0; k < LAT; k++) begin
         check($sformatf("%s_wait_rdy", name), 32'(RDY), 32'd0);
         step();
      end
      check($sformatf("%s_rdy", name), 32'(RDY), 32'd1);
      check_released($sformatf("%s_nodrive", name));
      CS = 1'b0;
      step();
      check($sformatf("%s_rdy_pulse", name), 32'(RDY), 32'd0);
   endtask

   task automatic read_op(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] exp,
                          input bit hold, input string name);
      sb_q.push_back(exp);
      CS = 1'b1; OE = 1'b1; WE = 1'b0; address = a;
      for (int k = 0; k < 1 + LAT; k++) begin
         step();
         check($sformatf("%s_early_rdy", name), 32'(RDY), 32'd0);
         check_released($sformatf("%s_early_bus", name));
      end
      step();
      check($sformatf("%s_rdy", name), 32'(RDY), 32'd1);
      sb_pop_check($sformatf("%s_data", name));
      if (!hold) begin
         CS = 1'b0; OE = 1'b0;
         #1;
         check_released($sformatf("%s_release", name));
         step();
         check($sformatf("%s_idle_rdy", name), 32'(RDY), 32'd0);
         check($sformatf("%s_idle_busy", name), 32'(busy), 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{waddr: 16'h0010, wdata: 8'hA5, raddr: 16'h0010, rexp: 8'hA5};
      vecs[1] = '{waddr: 16'h0011, wdata: 8'h5A, raddr: 16'h0011, rexp: 8'h5A};
      vecs[2] = '{waddr: 16'h0105, wdata: 8'h3C, raddr: 16'h0005, rexp: 8'h3C};
      vecs[3] = '{waddr: 16'h00FF, wdata: 8'h81, raddr: 16'hFFFF, rexp: 8'h81};
      vecs[4] = '{waddr: 16'h0020, wdata: 8'h77, raddr: 16'h0020, rexp: 8'h77};
      vecs[5] = '{waddr: 16'h1234, wdata: 8'hC3, raddr: 16'h0034, rexp: 8'hC3};

      reset = 1'b1; CS = 1'b0; OE = 1'b0; WE = 1'b0; address = '0;
      tb_en = 1'b0; tb_val = '0;
      step();
      step();
      check("reset_rdy", 32'(RDY), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check_released("reset_bus");
      reset = 1'b0;
      step();

      for (int i = 0; i < 6; i++) begin
         write_op(vecs[i].waddr, vecs[i].wdata, $sformatf("vec%0d_wr", i));
      end
      for (int i = 0; i < 6; i++) begin
         read_op(vecs[i].raddr, vecs[i].rexp, 1'b0, $sformatf("vec%0d_rd", i));
      end

      // Address change while DRIVE: RDY drops for one cycle, then the new data
      read_op(16'h0010, 8'hA5, 1'b1, "chg_first");
      address = 16'h0011;
      sb_q.push_back(8'h5A);
      step();
      check("chg_rdy_drop", 32'(RDY), 32'd0);
      check_released("chg_bus_gap");
      step();
      check("chg_rdy", 32'(RDY), 32'd1);
      sb_pop_check("chg_data");
      CS = 1'b0; OE = 1'b0;
      step();

      // WE and OE together: write wins, block never drives
      CS = 1'b1; WE = 1'b1; OE = 1'b1; address = 16'h0030; tb_en = 1'b1; tb_val = 8'h66;
      step();
      WE = 1'b0; OE = 1'b0; tb_en = 1'b0;
      #1;
      check_released("cont_bus0");
      for (int k = 0; k < LAT; k++) begin
         check("cont_wait_rdy", 32'(RDY), 32'd0);
         step();
         check_released("cont_bus_wait");
      end
      check("cont_rdy", 32'(RDY), 32'd1);
      CS = 1'b0;
      step();
      check("cont_rdy_pulse", 32'(RDY), 32'd0);
      check("cont_busy", 32'(busy), 32'd0);
      check_released("cont_bus1");
      read_op(16'h0030, 8'h66, 1'b0, "cont_rb");

      // Reset while in DRIVE with CS/OE still high
      read_op(16'h0010, 8'hA5, 1'b1, "rst_rd");
      reset = 1'b1;
      step();
      reset = 1'b0; CS = 1'b0; OE = 1'b0;
      check("rst_rdy", 32'(RDY), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_released("rst_bus");
      step();
      check("rst_idle_rdy", 32'(RDY), 32'd0);
      read_op(16'h0020, 8'h77, 1'b0, "rst_keep");

`ifdef MEM_WAIT_EN
      // CS dropped during WAIT aborts the read
      CS = 1'b1; OE = 1'b1; address = 16'h0010;
      step();
      check("abort_rdy0", 32'(RDY), 32'd0);
      CS = 1'b0; OE = 1'b0;
      step();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rdy1", 32'(RDY), 32'd0);
      check_released("abort_bus");
      step();
      check("abort_rdy2", 32'(RDY), 32'd0);
`endif

      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
